// File: rtl/bcd_display_feeder.sv
// Sequential double-dabble binary-to-BCD converter with saturation, holding a stable
// packed-BCD word for a 4-digit display. Optional auto-refresh via `define AUTO_REFRESH_EN.
module bcd_display_feeder #(
  parameter int IN_WIDTH    = 16,
  parameter int MAX_VALUE   = 9999,
  parameter int REFRESH_DIV = 1000000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [IN_WIDTH-1:0] bin,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [15:0]         bcd
);

  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [IN_WIDTH-1:0]   shift_q, shift_d;
  logic [15:0]           scratch_q, scratch_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [15:0]           bcd_q, bcd_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;

  logic                  start_eff;
  logic                  last_shift;
  logic                  saturate;
  logic [15:0]           adj;
  logic [16+IN_WIDTH-1:0] shifted;

`ifdef AUTO_REFRESH_EN
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [RW-1:0] refresh_q, refresh_d;
  logic          refresh_tick;

  // The tick coincides with the wrap edge, so the first auto start lands on edge REFRESH_DIV.
  assign refresh_tick = (refresh_q == RW'(REFRESH_DIV - 1));
  assign refresh_d    = refresh_tick ? '0 : refresh_q + RW'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) refresh_q <= '0;
    else          refresh_q <= refresh_d;
  end

  assign start_eff = start | refresh_tick;
`else
  assign start_eff = start;
`endif

  assign saturate   = (bin > IN_WIDTH'(MAX_VALUE));
  assign last_shift = (state_q == SHIFT) && (cnt_q == CW'(IN_WIDTH - 1));

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_eff)  state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on each digit, then one left shift of the combined register.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      adj[4*i +: 4] = (scratch_q[4*i +: 4] >= 4'd5) ? scratch_q[4*i +: 4] + 4'd3
                                                   : scratch_q[4*i +: 4];
    end
    shifted = {adj[14:0], shift_q, 1'b0};
  end

  // NOTE: every target gets a default first so no path leaves a variable unassigned (no latches).
  always_comb begin
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      if (start_eff) begin
        shift_d    = saturate ? IN_WIDTH'(MAX_VALUE) : bin;
        ovf_pend_d = saturate;
        scratch_d  = '0;
        cnt_d      = '0;
      end
    end else begin
      shift_d   = shifted[IN_WIDTH-1:0];
      scratch_d = shifted[16+IN_WIDTH-1:IN_WIDTH];
      cnt_d     = cnt_q + CW'(1);
      if (last_shift) begin
        bcd_d      = shifted[16+IN_WIDTH-1:IN_WIDTH];
        overflow_d = ovf_pend_q;
        done_d     = 1'b1;
      end
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign bcd      = bcd_q;

endmodule

// File: tb/tb_bcd_display_feeder.sv
// Self-checking bench for bcd_display_feeder: directed and random conversions against
// a decimal-arithmetic reference model.
module tb_bcd_display_feeder;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [15:0] bcd;

  int vectors    = 0;
  int miscompares = 0;

  bcd_display_feeder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .bcd      (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int unsigned v);
    int unsigned s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one conversion from an idle DUT; returns just after the done edge.
  task automatic run_conv(input logic [15:0] v, input bit wiggle);
    logic [15:0] hold_bcd;
    logic        hold_ovf;
    bin   = v;
    start = 1'b1;
    tick();
    start    = 1'b0;
    hold_bcd = bcd;
    hold_ovf = overflow;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (wiggle && i == 3) bin = 16'd55;
      check("busy_done_mid", {busy, done}, 2'b10);
      check("bcd_hold_mid", {overflow, bcd}, {hold_ovf, hold_bcd});
    end
    tick();
    check("done_pulse", {busy, done}, 2'b01);
    check("bcd_result", bcd, ref_bcd(v));
    check("overflow", overflow, (v > 16'd9999));
  endtask

  task automatic idle_cycles(input int n, input logic [15:0] exp_bcd);
    for (int i = 0; i < n; i++) begin
      tick();
      check("idle_busy_done", {busy, done}, 2'b00);
      check("idle_bcd", bcd, exp_bcd);
    end
  endtask

  initial begin
    logic [15:0] v;
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = 16'd0;
    tick();
    tick();
    check("reset_state", {busy, done, overflow, bcd}, 19'd0);
    reset_n = 1'b1;
    idle_cycles(5, 16'h0000);

    run_conv(16'd1234, 1'b0);
    idle_cycles(1, 16'h1234);
    run_conv(16'd9999, 1'b0);
    run_conv(16'd10000, 1'b0);
    run_conv(16'd65535, 1'b0);
    idle_cycles(2, 16'h9999);
    run_conv(16'd0, 1'b1);
    run_conv(16'd7, 1'b1);
    run_conv(16'd4095, 1'b1);
    idle_cycles(1, 16'h4095);

    // start while busy is ignored and not queued
    bin   = 16'd42;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    bin   = 16'd99;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("ignored_busy_mid", {busy, done}, 2'b10);
    tick();
    check("ignored_done", {busy, done}, 2'b01);
    check("ignored_bcd", bcd, 16'h0042);
    // start in the done cycle is accepted
    run_conv(16'd99, 1'b0);
    idle_cycles(20, 16'h0099);

    // reset in the middle of a conversion abandons it
    bin   = 16'd8888;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset_n = 1'b0;
    #1;
    check("async_reset", {busy, done, overflow, bcd}, 19'd0);
    tick();
    tick();
    reset_n = 1'b1;
    idle_cycles(30, 16'h0000);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'($urandom);
        1:       v = 16'($urandom_range(0, 9999));
        2:       v = 16'($urandom_range(9990, 10010));
        default: v = 16'($urandom_range(0, 20));
      endcase
      run_conv(v, ($urandom_range(0, 1) == 1));
      idle_cycles($urandom_range(0, 2), ref_bcd(v));
    end

    // No start means no conversion in the default build
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    bin     = 16'd321;
    idle_cycles(100, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
